watchdog_controller: RTL and testbench
======================================

# watchdog_controller

Programmable watchdog sequencer for the ARMAria control unit. It paces a timeout counter through a configurable prescaler. On the first timeout it raises a maskable interruption; on a second, unserviced timeout it escalates to a sticky system reset request. Software services it with `kick`, and configuration is locked while the watchdog is armed.

## Interface
- `COUNTER_SIZE`, default 16: width of the timeout counter and period register.
- `PRESCALE_SIZE`, default 4: width of the prescale register.
- `clock` in 1: single clock; all state updates on posedge.
- `reset` in 1: asynchronous, active-high; clears all state immediately.
- `enable` in 1: level; 1 arms the watchdog, 0 disarms it (except from EXPIRED).
- `config_write` in 1: one-cycle strobe; captures `config_period` and `config_prescale`.
- `config_period` in COUNTER_SIZE: timeout period N.
- `config_prescale` in PRESCALE_SIZE: prescale value p; one tick every p+1 clocks.
- `kick` in 1: one-cycle service strobe.
- `interruption_ack` in 1: one-cycle strobe; clears `interruption`.
- `interruption` out 1: registered warning interrupt.
- `system_reset_request` out 1: registered, sticky escalation.
- `count` out COUNTER_SIZE: current timeout count.
- `state` out 2: current FSM state.

## Operation
- States: DISABLED=0, RUNNING=1, WARNING=2, EXPIRED=3.
- Reset values:
  - state DISABLED; `count` 0; `interruption` 0; `system_reset_request` 0.
  - period register 2^(COUNTER_SIZE-1); prescale register 0; prescaler 0.
- Prescaler: counts 0..p and asserts `tick` while at p, then wraps to 0. It is cleared on every state change and on every accepted kick.
- DISABLED:
  - `count` is held at 0.
  - `config_write` loads both registers.
  - `enable`=1 → RUNNING with `count`=0. If `config_write` occurs in the same cycle, the new values apply.
- RUNNING:
  - `tick` increments `count`.
  - `tick` with `count`==N → WARNING: `count` goes to 0 and `interruption` is set.
  - `kick` → `count` 0, stays RUNNING.
- WARNING:
  - Counting continues as in RUNNING.
  - `interruption_ack` clears `interruption`; state stays WARNING.
  - `kick` → RUNNING: `count` 0, `interruption` cleared.
  - `tick` with `count`==N → EXPIRED: `system_reset_request` is set and `interruption` is held.
- EXPIRED:
  - `count` is frozen.
  - `kick`, `enable`, `config_write` and `interruption_ack` are all ignored.
  - Only `reset` leaves this state.
- `config_write` outside DISABLED is ignored (lockout).
- Arithmetic: `count` never passes N, so it cannot wrap. N=0 means a timeout on the first tick.
- Simultaneous events, in priority order:
  1. `reset` overrides everything.
  2. In RUNNING/WARNING, `enable`=0 → DISABLED. This beats kick and timeout and clears `interruption`.
  3. `kick` beats a same-cycle timeout tick.
  4. `kick` beats `interruption_ack`.

## Timing
- All outputs are registered; there are no combinational input-to-output paths.
- `interruption` rises exactly (N+1)(p+1) clocks after the edge that enters RUNNING, assuming no kicks.
- `system_reset_request` rises (N+1)(p+1) clocks after the edge that enters WARNING.
- A kick restarts the full (N+1)(p+1) interval, measured from the edge that samples it.
- `interruption_ack` takes effect on the next edge, so the output falls one cycle after the strobe.
- Asserting `reset` mid-operation zeroes the outputs asynchronously, without waiting for a clock edge.

## Structure
- Package `watchdog_pkg`:
  - state encoding constants DISABLED/RUNNING/WARNING/EXPIRED;
  - `DEFAULT_PERIOD` function of COUNTER_SIZE;
  - `DEFAULT_PRESCALE`=0.
- Sub-module `tick_prescaler` (`clock`, `reset`, `clear`, `prescale`, `tick`): a PRESCALE_SIZE counter producing a single-cycle `tick`.
- Top level holds the FSM, period/prescale registers, timeout counter and output flops.

## Test plan
Bench uses COUNTER_SIZE=8, PRESCALE_SIZE=4.
1. Write N=3, p=1; enable, no kicks → `interruption`=1 8 clocks after RUNNING entry, `state`=2; `system_reset_request`=1 8 clocks later, `state`=3.
2. Same configuration; kick in the cycle of the 4th tick (the timeout tick) → no interruption, `count`=0, state stays 1; the next timeout comes 8 clocks after the kick.
3. In WARNING, pulse `interruption_ack` → `interruption`=0 next cycle, `state`=2; then kick → `state`=1, `count`=0.
4. In RUNNING, `config_write` with N=1 → ignored, timeout still at 8 clocks. Disable, write N=1, enable → timeout at 4 clocks.
5. In EXPIRED, drive `enable`=0, `kick`, `config_write` → `state` stays 3 and `system_reset_request` stays 1. Assert `reset` mid-clock → all outputs 0 before the next edge.
6. With N=0, p=0 → `interruption` rises 1 clock after RUNNING entry. Assert `enable`=0 together with `kick` → `state`=0, `interruption`=0.

Source files
------------

// File: rtl/watchdog_pkg.sv
// Shared definitions for the watchdog controller: FSM state encoding and
// the register values restored on reset.
package watchdog_pkg;

    typedef enum logic [1:0] {
        DISABLED = 2'd0,
        RUNNING  = 2'd1,
        WARNING  = 2'd2,
        EXPIRED  = 2'd3
    } state_t;

    localparam int DEFAULT_PRESCALE = 0;

    // Reset period is half the counter range, so an unconfigured watchdog
    // still times out eventually.
    function automatic logic [31:0] DEFAULT_PERIOD(input int size);
        return 32'd1 << (size - 1);
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running divider that emits a one-cycle tick every prescale+1 clocks.
// While clear is high the divider is held at zero.
module tick_prescaler #(
    parameter int PRESCALE_SIZE = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     clear,
    input  logic [PRESCALE_SIZE-1:0] prescale,
    output logic                     tick
);

    logic [PRESCALE_SIZE-1:0] divider;

    assign tick = (divider == prescale);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            divider <= '0;
        end else if (clear || tick) begin
            divider <= '0;
        end else begin
            divider <= divider + PRESCALE_SIZE'(1);
        end
    end

endmodule

// File: rtl/watchdog_controller.sv
// Two-stage watchdog: a first timeout raises an interrupt, a second
// unserviced timeout latches a system reset request until reset.
module watchdog_controller
    import watchdog_pkg::*;
#(
    parameter int COUNTER_SIZE  = 16,
    parameter int PRESCALE_SIZE = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     enable,
    input  logic                     config_write,
    input  logic [COUNTER_SIZE-1:0]  config_period,
    input  logic [PRESCALE_SIZE-1:0] config_prescale,
    input  logic                     kick,
    input  logic                     interruption_ack,
    output logic                     interruption,
    output logic                     system_reset_request,
    output logic [COUNTER_SIZE-1:0]  count,
    output logic [1:0]               state
);

    state_t                   fsm_state;
    logic [COUNTER_SIZE-1:0]  period;
    logic [PRESCALE_SIZE-1:0] prescale;
    logic                     armed;
    logic                     clear;
    logic                     tick;
    logic                     timeout;

    assign armed   = (fsm_state == RUNNING) || (fsm_state == WARNING);
    // Divider restarts whenever the watchdog is idle, disarmed, or serviced,
    // so every interval begins on a clean prescale boundary.
    assign clear   = !armed || !enable || kick;
    assign timeout = tick && (count == period);
    assign state   = fsm_state;

    tick_prescaler #(
        .PRESCALE_SIZE(PRESCALE_SIZE)
    ) u_prescaler (
        .clock   (clock),
        .reset   (reset),
        .clear   (clear),
        .prescale(prescale),
        .tick    (tick)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fsm_state            <= DISABLED;
            count                <= '0;
            interruption         <= 1'b0;
            system_reset_request <= 1'b0;
            period               <= COUNTER_SIZE'(DEFAULT_PERIOD(COUNTER_SIZE));
            prescale             <= PRESCALE_SIZE'(DEFAULT_PRESCALE);
        end else begin
            case (fsm_state)
                DISABLED: begin
                    count <= '0;
                    if (config_write) begin
                        period   <= config_period;
                        prescale <= config_prescale;
                    end
                    if (enable) begin
                        fsm_state <= RUNNING;
                    end
                end
                RUNNING, WARNING: begin
                    if (!enable) begin
                        fsm_state    <= DISABLED;
                        count        <= '0;
                        interruption <= 1'b0;
                    end else if (kick) begin
                        fsm_state    <= RUNNING;
                        count        <= '0;
                        interruption <= 1'b0;
                    end else begin
                        if (interruption_ack) begin
                            interruption <= 1'b0;
                        end
                        if (timeout) begin
                            count <= '0;
                            if (fsm_state == RUNNING) begin
                                fsm_state    <= WARNING;
                                interruption <= 1'b1;
                            end else begin
                                // Escalation keeps the interrupt at its current level.
                                fsm_state            <= EXPIRED;
                                system_reset_request <= 1'b1;
                                interruption         <= interruption;
                            end
                        end else if (tick) begin
                            count <= count + COUNTER_SIZE'(1);
                        end
                    end
                end
                EXPIRED: begin
                    fsm_state <= EXPIRED;
                end
                default: begin
                    fsm_state <= DISABLED;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_watchdog_controller.sv
// Directed bench for watchdog_controller: stimulus queues expected snapshots
// tagged with the clock edge they belong to; a monitor checks them.
module tb_watchdog_controller;

    localparam int CS = 8;
    localparam int PS = 4;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          enable = 1'b0;
    logic          config_write = 1'b0;
    logic [CS-1:0] config_period = '0;
    logic [PS-1:0] config_prescale = '0;
    logic          kick = 1'b0;
    logic          interruption_ack = 1'b0;
    logic          interruption;
    logic          system_reset_request;
    logic [CS-1:0] count;
    logic [1:0]    state;

    watchdog_controller #(
        .COUNTER_SIZE (CS),
        .PRESCALE_SIZE(PS)
    ) dut (
        .clock               (clock),
        .reset               (reset),
        .enable              (enable),
        .config_write        (config_write),
        .config_period       (config_period),
        .config_prescale     (config_prescale),
        .kick                (kick),
        .interruption_ack    (interruption_ack),
        .interruption        (interruption),
        .system_reset_request(system_reset_request),
        .count               (count),
        .state               (state)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        string      name;
        logic [1:0] st;
        int         cnt;
        logic       intr;
        logic       srr;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic expect_at(input int c, input string n, input logic [1:0] st,
                             input int cnt, input logic intr, input logic srr);
        exp_t e;
        e.cyc = c; e.name = n; e.st = st; e.cnt = cnt; e.intr = intr; e.srr = srr;
        sb.push_back(e);
    endtask

    always @(negedge clock) begin : monitor
        exp_t e;
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            checks = checks + 1;
            if (e.cyc < cyc) begin
                errors = errors + 1;
                $display("FAIL %s: expectation for cycle %0d missed (now cycle %0d)", e.name, e.cyc, cyc);
            end else if (state !== e.st || int'(count) != e.cnt ||
                         interruption !== e.intr || system_reset_request !== e.srr) begin
                errors = errors + 1;
                $display("FAIL %s @%0d: got state=%0d count=%0d intr=%b srr=%b, want state=%0d count=%0d intr=%b srr=%b",
                         e.name, cyc, state, count, interruption, system_reset_request,
                         e.st, e.cnt, e.intr, e.srr);
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Returns just after edge c+1, so the check for edge c has been made.
    task automatic run_to(input int c);
        while (cyc <= c) step();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        enable = 1'b0;
        kick = 1'b0;
        config_write = 1'b0;
        interruption_ack = 1'b0;
        step();
        reset = 1'b0;
    endtask

    task automatic write_config(input int n, input int p);
        config_period = CS'(n);
        config_prescale = PS'(p);
        config_write = 1'b1;
        step();
        config_write = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: bench did not finish, cycle=%0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int e0, w, k, e1, e2;

        // Reset state
        step(); step();
        expect_at(cyc, "reset_values", 2'd0, 0, 1'b0, 1'b0);
        step();
        reset = 1'b0;
        step();

        // 1: N=3, p=1, no kicks
        write_config(3, 1);
        enable = 1'b1;
        e0 = cyc + 1;
        expect_at(e0,      "t1_enter",   2'd1, 0, 1'b0, 1'b0);
        expect_at(e0 + 2,  "t1_tick1",   2'd1, 1, 1'b0, 1'b0);
        expect_at(e0 + 7,  "t1_pre_int", 2'd1, 3, 1'b0, 1'b0);
        expect_at(e0 + 8,  "t1_warning", 2'd2, 0, 1'b1, 1'b0);
        expect_at(e0 + 15, "t1_pre_exp", 2'd2, 3, 1'b1, 1'b0);
        expect_at(e0 + 16, "t1_expired", 2'd3, 0, 1'b1, 1'b1);
        run_to(e0 + 16);

        // 2: kick on the timeout tick
        do_reset();
        write_config(3, 1);
        enable = 1'b1;
        e0 = cyc + 1;
        expect_at(e0,      "t2_enter",     2'd1, 0, 1'b0, 1'b0);
        expect_at(e0 + 8,  "t2_kick_wins", 2'd1, 0, 1'b0, 1'b0);
        expect_at(e0 + 15, "t2_pre_int",   2'd1, 3, 1'b0, 1'b0);
        expect_at(e0 + 16, "t2_warning",   2'd2, 0, 1'b1, 1'b0);
        run_to(e0 + 6);
        kick = 1'b1;
        step();
        kick = 1'b0;
        run_to(e0 + 15);

        // 3: acknowledge then kick in WARNING
        w = e0 + 16;
        interruption_ack = 1'b1;
        expect_at(w + 1, "t3_ack",  2'd2, 0, 1'b0, 1'b0);
        step();
        interruption_ack = 1'b0;
        kick = 1'b1;
        expect_at(w + 2, "t3_kick", 2'd1, 0, 1'b0, 1'b0);
        step();
        kick = 1'b0;

        // 4: config lockout while armed, then reconfigure while disabled
        k = w + 2;
        expect_at(k + 7, "t4_locked_pre", 2'd1, 3, 1'b0, 1'b0);
        expect_at(k + 8, "t4_locked_int", 2'd2, 0, 1'b1, 1'b0);
        write_config(1, 1);
        run_to(k + 8);
        enable = 1'b0;
        expect_at(k + 10, "t4_disable", 2'd0, 0, 1'b0, 1'b0);
        step();
        write_config(1, 1);
        enable = 1'b1;
        e1 = cyc + 1;
        expect_at(e1,     "t4_enter",   2'd1, 0, 1'b0, 1'b0);
        expect_at(e1 + 3, "t4_pre_int", 2'd1, 1, 1'b0, 1'b0);
        expect_at(e1 + 4, "t4_warning", 2'd2, 0, 1'b1, 1'b0);

        // 5: EXPIRED ignores everything but reset
        expect_at(e1 + 7, "t5_pre_exp", 2'd2, 1, 1'b1, 1'b0);
        expect_at(e1 + 8, "t5_expired", 2'd3, 0, 1'b1, 1'b1);
        run_to(e1 + 7);
        enable = 1'b0;
        kick = 1'b1;
        interruption_ack = 1'b1;
        config_period = 8'd5;
        config_write = 1'b1;
        for (int i = 9; i <= 11; i++) expect_at(e1 + i, "t5_hold", 2'd3, 0, 1'b1, 1'b1);
        run_to(e1 + 10);
        kick = 1'b0;
        interruption_ack = 1'b0;
        config_write = 1'b0;
        step();
        expect_at(cyc, "t5_async_reset", 2'd0, 0, 1'b0, 1'b0);
        #1 reset = 1'b1;
        step();
        reset = 1'b0;

        // 6: N=0, p=0, config and enable in one cycle; disable beats kick
        config_period = 8'd0;
        config_prescale = 4'd0;
        config_write = 1'b1;
        enable = 1'b1;
        e2 = cyc + 1;
        expect_at(e2,     "t6_enter",        2'd1, 0, 1'b0, 1'b0);
        expect_at(e2 + 1, "t6_warning",      2'd2, 0, 1'b1, 1'b0);
        expect_at(e2 + 2, "t6_disable_kick", 2'd0, 0, 1'b0, 1'b0);
        step();
        config_write = 1'b0;
        step();
        enable = 1'b0;
        kick = 1'b1;
        step();
        kick = 1'b0;
        step();

        // 7: reset-default period is 128, so count climbs freely with p=0
        do_reset();
        enable = 1'b1;
        e2 = cyc + 1;
        expect_at(e2 + 5,  "t7_default_cnt5",  2'd1, 5, 1'b0, 1'b0);
        expect_at(e2 + 40, "t7_default_cnt40", 2'd1, 40, 1'b0, 1'b0);
        run_to(e2 + 40);
        enable = 1'b0;
        step();
        step();

        if (sb.size() != 0) begin
            checks = checks + 1;
            errors = errors + 1;
            $display("FAIL scoreboard_drain: %0d expectations left, want 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
